clrx_align_ctrl: RTL
====================

Name: clrx_align_ctrl

Overview:
Per-channel link bring-up controller for one Camera Link LVDS receiver (X, Y or Z). It waits for the channel MMCM to lock, then resets the ISERDES. It scans the IDELAY taps for the widest stable eye on the deserialized 7-bit clock lane, centres the tap, and bitslips until the 7'b1100011 clock pattern is framed. It then holds the channel FIFO in reset until alignment completes, and keeps monitoring for loss of lock or loss of pattern.

Parameters:
NUM_TAPS, 32, IDELAY taps scanned (0..NUM_TAPS-1)
TAP_W, 5, tap value width
LOCK_FILT, 8, consecutive locked cycles required before starting
SERDES_RST_CYC, 4, iserdes_rst pulse length
SETTLE_CYC, 16, wait after any tap load or bitslip
CHECK_CYC, 64, samples compared per tap / per pattern check
MIN_EYE, 4, minimum stable-window width in taps
CLK_PATTERN, 7'b1100011, expected framed clock-lane word
LOSS_CNT, 4, consecutive bad words in DONE that trigger re-alignment

Ports:
sys_clk  in  1  clock; clk_word is synchronous to it
rst  in  1  synchronous reset, active-high
locked  in  1  channel MMCM LOCKED (pre-synchronized)
clk_word  in  7  deserialized clock-lane word, one per cycle
realign  in  1  software re-alignment request (single-cycle pulse)
iserdes_rst  out  1  ISERDES reset
idelay_ld  out  1  one-cycle load strobe for IDELAY CNTVALUEIN
idelay_tap  out  TAP_W  tap value; valid while idelay_ld is high, held otherwise
bitslip  out  1  one-cycle ISERDES bitslip pulse
fifo_rst  out  1  channel FIFO reset
aligned  out  1  channel aligned and monitored good
align_err  out  1  sticky error: eye too narrow or pattern not found
eye_start  out  TAP_W  first tap of the chosen window
eye_len  out  TAP_W+1  width of the chosen window
slip_cnt  out  3  bitslips applied

Behaviour:
- Reset values: iserdes_rst=1, fifo_rst=1, all other outputs 0; state=WAIT_LOCK.
- WAIT_LOCK: lock counter increments while locked=1 and clears on locked=0. When it reaches LOCK_FILT, go to SRST.
- SRST: iserdes_rst=1 for SERDES_RST_CYC cycles; tap=0; clear window registers; go to LOAD.
- LOAD: idelay_ld=1 for exactly one cycle with idelay_tap=current tap; go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles. Next state is SCAN, or CHKPAT if the tap scan is already complete.
- SCAN:
  - First sample is latched as ref; the next CHECK_CYC-1 samples are compared to it.
  - Tap passes if all samples match.
  - Pass: cur_len++ (cur_start=tap if cur_len was 0).
  - Fail: if cur_len>best_len, copy cur to best; then clear cur_len.
- Scan end: after tap NUM_TAPS-1, perform the final cur-vs-best compare. The window does not wrap across tap 0.
  - best_len<MIN_EYE: align_err=1, go to ERROR.
  - Otherwise tap = best_start + (best_len>>1) (floor), then LOAD; the following SETTLE exits to CHKPAT.
- Ties between equal-length windows: keep the lowest-tap window (strict > compare).
- CHKPAT: pass requires clk_word==CLK_PATTERN for CHECK_CYC consecutive cycles; go to DONE.
  - On first mismatch: if slip_cnt==6, align_err=1 and go to ERROR.
  - Otherwise pulse bitslip for 1 cycle, slip_cnt++, go to SETTLE.
- DONE:
  - aligned=1; fifo_rst=0 on the cycle after entry.
  - Bad-word counter increments on mismatch and clears on match.
  - At LOSS_CNT, or on locked=0, drop aligned and fifo_rst=1 in the same cycle as the transition.
  - Loss of lock goes to WAIT_LOCK; pattern loss goes to SRST.
- ERROR: outputs frozen, fifo_rst=1. Leave only on realign (to SRST; clears align_err and slip_cnt) or on locked=0 (to WAIT_LOCK).
- realign in any state except WAIT_LOCK: go to SRST next cycle, aligned=0, fifo_rst=1.
- locked=0 in any state goes to WAIT_LOCK and overrides a simultaneous realign.
- eye_start and eye_len update at scan end only; slip_cnt clears in SRST.
- rst mid-operation returns to the reset values on the next edge.

Test Plan:
- locked pulses 1,0 then held 1; clk_word stable only on taps 10..19 → idelay_tap loaded 15; eye_start=10, eye_len=10; aligned=1 after pattern checks.
- Stable windows on taps 2..7 and 20..25 → lowest window chosen, tap=5; windows 3..5 and 28..31 (len 4 at the end) → 28..31 chosen, tap=30.
- Eye only taps 4..6 (len 3) → align_err=1, fifo_rst=1, no bitslip; then realign → scan restarts from tap 0.
- Clock word rotated by 3 slips → exactly 3 bitslip pulses, each separated by ≥SETTLE_CYC cycles; slip_cnt=3; aligned=1.
- Pattern never matches → 6 bitslips, then align_err=1, aligned=0.
- In DONE: 4 consecutive bad words → aligned=0 and fifo_rst=1 in the same cycle, re-scan starts; separately, locked=0 asserted with realign in the same cycle → WAIT_LOCK.

Source files
------------

// File: rtl/clrx_align_ctrl.sv
// clrx_align_ctrl: bring-up controller for one Camera Link LVDS receiver channel.
// It waits for MMCM lock, resets the ISERDES, and scans the IDELAY taps for the
// widest stable eye on the clock lane. It then centres the tap, bitslips until
// the clock word is framed, and monitors the aligned link.
module clrx_align_ctrl #(
    parameter int         NUM_TAPS       = 32,
    parameter int         TAP_W          = 5,
    parameter int         LOCK_FILT      = 8,
    parameter int         SERDES_RST_CYC = 4,
    parameter int         SETTLE_CYC     = 16,
    parameter int         CHECK_CYC      = 64,
    parameter int         MIN_EYE        = 4,
    parameter logic [6:0] CLK_PATTERN    = 7'b1100011,
    parameter int         LOSS_CNT       = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             locked,
    input  logic [6:0]       clk_word,
    input  logic             realign,
    output logic             iserdes_rst,
    output logic             idelay_ld,
    output logic [TAP_W-1:0] idelay_tap,
    output logic             bitslip,
    output logic             fifo_rst,
    output logic             aligned,
    output logic             align_err,
    output logic [TAP_W-1:0] eye_start,
    output logic [TAP_W:0]   eye_len,
    output logic [2:0]       slip_cnt
);

    localparam int CNT_W = 16;
    localparam int LEN_W = TAP_W + 1;

    typedef enum logic [2:0] {
        WAIT_LOCK, SRST, LOAD, SETTLE, SCAN, CHKPAT, DONE, ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [6:0]         ref_q, ref_d;
    logic               match_q, match_d;
    logic [TAP_W-1:0]   cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [LEN_W-1:0]   cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic               scan_done_q, scan_done_d;
    logic [2:0]         slip_cnt_q, slip_cnt_d;
    logic               align_err_q, align_err_d;
    logic [TAP_W-1:0]   eye_start_q, eye_start_d;
    logic [LEN_W-1:0]   eye_len_q, eye_len_d;
    logic               bitslip_q, bitslip_d;
    logic               in_done_q, in_done_d;
    logic               restart;

    logic               word_ok, last_tap;
    logic [TAP_W-1:0]   c_start, b_start, centre;
    logic [LEN_W-1:0]   c_len, b_len;

    // Fold the result of the tap being scanned into the current/best windows.
    always_comb begin
        word_ok  = (cnt_q == '0) || (match_q && (clk_word == ref_q));
        last_tap = (tap_q == TAP_W'(NUM_TAPS - 1));
        c_start  = cur_start_q;
        c_len    = cur_len_q;
        b_start  = best_start_q;
        b_len    = best_len_q;
        if (word_ok) begin
            if (cur_len_q == '0) c_start = tap_q;
            c_len = cur_len_q + LEN_W'(1);
        end else begin
            if (cur_len_q > best_len_q) begin
                b_start = cur_start_q;
                b_len   = cur_len_q;
            end
            c_len = '0;
        end
        if (last_tap && (c_len > b_len)) begin
            b_start = c_start;
            b_len   = c_len;
        end
        centre = b_start + TAP_W'(b_len >> 1);
    end

    // Next-state logic; lock loss beats realign, and both beat normal sequencing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        tap_d        = tap_q;
        ref_d        = ref_q;
        match_d      = match_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        scan_done_d  = scan_done_q;
        slip_cnt_d   = slip_cnt_q;
        align_err_d  = align_err_q;
        eye_start_d  = eye_start_q;
        eye_len_d    = eye_len_q;
        bitslip_d    = 1'b0;
        restart      = 1'b0;

        if (!locked) begin
            state_d = WAIT_LOCK;
            restart = 1'b1;
        end else if (realign && (state_q != WAIT_LOCK)) begin
            state_d     = SRST;
            restart     = 1'b1;
            align_err_d = 1'b0;
            slip_cnt_d  = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (cnt_q == CNT_W'(LOCK_FILT - 1)) state_d = SRST;
                end
                SRST: begin
                    tap_d        = '0;
                    cur_start_d  = '0;
                    cur_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    scan_done_d  = 1'b0;
                    slip_cnt_d   = '0;
                    if (cnt_q == CNT_W'(SERDES_RST_CYC - 1)) state_d = LOAD;
                end
                LOAD: begin
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1))
                        state_d = scan_done_q ? CHKPAT : SCAN;
                end
                SCAN: begin
                    if (cnt_q == '0) ref_d = clk_word;
                    match_d = word_ok;
                    if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
                        cur_start_d  = c_start;
                        cur_len_d    = c_len;
                        best_start_d = b_start;
                        best_len_d   = b_len;
                        if (last_tap) begin
                            scan_done_d = 1'b1;
                            eye_start_d = b_start;
                            eye_len_d   = b_len;
                            if (b_len < LEN_W'(MIN_EYE)) begin
                                align_err_d = 1'b1;
                                state_d     = ERROR;
                            end else begin
                                tap_d   = centre;
                                state_d = LOAD;
                            end
                        end else begin
                            tap_d   = tap_q + TAP_W'(1);
                            state_d = LOAD;
                        end
                    end
                end
                CHKPAT: begin
                    if (clk_word != CLK_PATTERN) begin
                        if (slip_cnt_q == 3'd6) begin
                            align_err_d = 1'b1;
                            state_d     = ERROR;
                        end else begin
                            bitslip_d  = 1'b1;
                            slip_cnt_d = slip_cnt_q + 3'd1;
                            state_d    = SETTLE;
                        end
                    end else if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (clk_word != CLK_PATTERN) begin
                        if (cnt_q == CNT_W'(LOSS_CNT - 1)) state_d = SRST;
                    end else begin
                        cnt_d = '0;
                    end
                end
                ERROR: begin
                    cnt_d = cnt_q;
                end
                default: state_d = WAIT_LOCK;
            endcase
        end

        if (restart || (state_d != state_q)) cnt_d = '0;
        in_done_d = (state_q == DONE) && (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            tap_q        <= '0;
            ref_q        <= '0;
            match_q      <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            scan_done_q  <= 1'b0;
            slip_cnt_q   <= '0;
            align_err_q  <= 1'b0;
            eye_start_q  <= '0;
            eye_len_q    <= '0;
            bitslip_q    <= 1'b0;
            in_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            ref_q        <= ref_d;
            match_q      <= match_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            scan_done_q  <= scan_done_d;
            slip_cnt_q   <= slip_cnt_d;
            align_err_q  <= align_err_d;
            eye_start_q  <= eye_start_d;
            eye_len_q    <= eye_len_d;
            bitslip_q    <= bitslip_d;
            in_done_q    <= in_done_d;
        end
    end

    assign iserdes_rst = (state_q == WAIT_LOCK) || (state_q == SRST);
    assign idelay_ld   = (state_q == LOAD);
    assign idelay_tap  = tap_q;
    assign bitslip     = bitslip_q;
    assign aligned     = (state_q == DONE);
    assign fifo_rst    = !((state_q == DONE) && in_done_q);
    assign align_err   = align_err_q;
    assign eye_start   = eye_start_q;
    assign eye_len     = eye_len_q;
    assign slip_cnt    = slip_cnt_q;

endmodule
